ex_div: RTL
===========

# ex_div

Parametrised multi-cycle integer divider that sits beside the execute-stage ALU and serves the `div`/`divu` instructions. It performs a restoring radix-2 division of a WIDTH-bit dividend by a WIDTH-bit divisor, in signed or unsigned mode. The result is packed `{remainder, quotient}` so it drops straight onto the Hi/Lo write path: Hi receives the remainder, Lo receives the quotient. `busy_o` is the pipeline stall request while a division is in flight.

## Interface
- WIDTH, 32: operand width in bits. Legal values are 8..64. The iteration counter is $clog2(WIDTH)+1 bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  request a division; level-held by the execute stage until the result is consumed.
- annul_i  input  1  cancel the operation in flight (flush on a branch or exception).
- signed_i  input  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with start_i.
- dividend_i  input  WIDTH  dividend; sampled with start_i.
- divisor_i  input  WIDTH  divisor; sampled with start_i.
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result_o is valid.
- busy_o  output  1  stall request; high in ON and ZERO.
- div_zero_o  output  1  the completed operation had divisor == 0.

## Operation
- States are IDLE, ZERO, ON and END. Reset forces IDLE and clears result_o, ready_o, div_zero_o, the counter and the working register.
- **IDLE**
  - start_i=1 and annul_i=0 latches the operands and signed_i.
  - If divisor_i == 0, go to ZERO. Otherwise go to ON with counter = 0.
  - start_i with annul_i=1 is ignored.
- **Operand preparation**
  - In signed mode, negative operands are replaced by their two's-complement magnitude.
  - Record the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
- **ON**
  - Working register is 2*WIDTH+1 bits; its upper half is the partial remainder.
  - Each cycle: shift left by 1, trial-subtract the divisor magnitude from the upper half.
  - If the difference is non-negative, keep it and set the LSB (quotient bit) to 1; else restore and set the LSB to 0.
  - Increment the counter.
  - After the WIDTH-th step, go to END. On that edge, apply the sign correction and register result_o, set ready_o=1, div_zero_o=0.
- **ZERO**: one cycle, then go to END with result_o = 0, ready_o=1, div_zero_o=1.
- **END**
  - result_o, ready_o and div_zero_o hold for as long as start_i=1.
  - start_i=0 returns to IDLE and clears result_o, ready_o and div_zero_o on the same edge.
- **annul_i**
  - annul_i=1 in ON or ZERO returns to IDLE on the next edge; ready_o never rises and result_o stays 0.
  - annul_i in END is ignored; END is left only through start_i=0.
- **Width and arithmetic rules**
  - Unsigned mode applies no sign correction.
  - The most-negative value divided by -1 (signed) returns quotient = most-negative value (wraps) and remainder = 0, with no flag.
  - The sign-correction negation is a WIDTH-bit two's complement.
- Simultaneous start_i and annul_i in IDLE counts as no request.

## Timing
- Let E0 be the edge that samples start_i.
- Normal path: steps occur on edges E1..EW; E(W+1) enters END. ready_o is high after W+1 edges following E0, which is 33 cycles after E0 for WIDTH=32.
- Divide by zero: E0 enters ZERO, E1 enters END.
- busy_o is decoded combinationally from the state, so it is high in the cycle after E0 and drops in the cycle ready_o rises.
- rst asserted at any point, including mid-ON, resets everything immediately, independent of clk.
- Back-to-back operations: a new start is accepted only from IDLE, so the minimum gap is one IDLE cycle after start_i falls.

## Configuration
- `EX_DIV_EARLY_TERM_EN`
  - **Defined:** in IDLE with a nonzero divisor and |dividend| < |divisor| (magnitudes per mode), skip ON. Go through ZERO-like single-cycle handling to END with quotient 0, remainder = dividend_i unchanged, and div_zero_o=0. Latency is 2 edges, with busy_o high for one cycle.
  - **Undefined:** every nonzero-divisor operation takes the full WIDTH-step path; results are identical.

## Test plan
- Unsigned 100 / 7 (WIDTH=32) -> after 33 cycles, ready_o=1, result_o={32'd2, 32'd14}, busy_o low from that cycle on.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
- Divisor 0 -> END after 2 edges, result_o=0, div_zero_o=1. Then drop start_i -> next cycle IDLE, all outputs 0.
- annul_i pulsed at step 10 of 100/7 -> IDLE, ready_o never rises. Then a fresh start with 9/3 -> {0, 3} at normal latency. rst dropped mid-ON -> outputs 0 immediately.
- With `EX_DIV_EARLY_TERM_EN` defined, unsigned 5 / 9 -> ready after 2 edges, {32'd5, 32'd0}. Without the macro, the same result after 33 cycles.

Source files
------------

// File: rtl/ex_div_if.sv
// Handshake bundle between the execute stage and the multi-cycle divider.
// The master is the execute stage; the slave is ex_div.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               annul;
  logic               signed_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               busy;
  logic               div_zero;

  modport master (
    output start, annul, signed_op, dividend, divisor,
    input  result, ready, busy, div_zero
  );

  modport slave (
    input  start, annul, signed_op, dividend, divisor,
    output result, ready, busy, div_zero
  );
endinterface

// File: rtl/ex_div.sv
// Restoring radix-2 divider for div/divu; result is {remainder, quotient}.
// Optional macro EX_DIV_EARLY_TERM_EN short-cuts |dividend| < |divisor|.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

  state_t             state;
  logic [2*WIDTH:0]   work;
  logic [WIDTH-1:0]   div_mag;
  logic [CW-1:0]      cnt;
  logic               q_neg;
  logic               r_neg;
  logic               early;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH:0]   work_step;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    a_neg     = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg     = bus.signed_op & bus.divisor[WIDTH-1];
    a_mag     = a_neg ? -bus.dividend : bus.dividend;
    b_mag     = b_neg ? -bus.divisor  : bus.divisor;
    shifted   = {work[2*WIDTH-1:0], 1'b0};
    diff      = shifted[2*WIDTH:WIDTH] - {1'b0, div_mag};
    work_step = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
    q_fix     = q_neg ? -work[WIDTH-1:0]       : work[WIDTH-1:0];
    r_fix     = r_neg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  assign bus.busy = (state == S_ON) || (state == S_ZERO);

`ifndef EX_DIV_EARLY_TERM_EN
  assign early = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      work         <= '0;
      div_mag      <= '0;
      cnt          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      bus.result   <= '0;
      bus.ready    <= 1'b0;
      bus.div_zero <= 1'b0;
`ifdef EX_DIV_EARLY_TERM_EN
      early        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.annul) begin
            work    <= {{(WIDTH+1){1'b0}}, a_mag};
            div_mag <= b_mag;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            cnt     <= '0;
`ifdef EX_DIV_EARLY_TERM_EN
            early   <= 1'b0;
`endif
            if (bus.divisor == '0) begin
              state <= S_ZERO;
`ifdef EX_DIV_EARLY_TERM_EN
            end else if (a_mag < b_mag) begin
              // Remainder is the raw dividend, parked in the working register.
              work  <= {{(WIDTH+1){1'b0}}, bus.dividend};
              early <= 1'b1;
              state <= S_ZERO;
`endif
            end else begin
              state <= S_ON;
            end
          end
        end

        S_ZERO: begin
          if (bus.annul) begin
            state <= S_IDLE;
          end else begin
            state        <= S_END;
            bus.result   <= early ? {work[WIDTH-1:0], {WIDTH{1'b0}}} : '0;
            bus.ready    <= 1'b1;
            bus.div_zero <= !early;
          end
        end

        S_ON: begin
          if (bus.annul) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            // All WIDTH steps done; this extra edge applies the sign fix-up.
            state        <= S_END;
            bus.result   <= {r_fix, q_fix};
            bus.ready    <= 1'b1;
            bus.div_zero <= 1'b0;
          end else begin
            work <= work_step;
            cnt  <= cnt + 1'b1;
          end
        end

        S_END: begin
          if (!bus.start) begin
            state        <= S_IDLE;
            bus.result   <= '0;
            bus.ready    <= 1'b0;
            bus.div_zero <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
